dm163_scan_ctrl: RTL and testbench

DM163_SCAN_CTRL -- requirements
Module: dm163_scan_ctrl

---
 rtl/dm163_scan_ctrl_if.sv | 39 +++
 rtl/dm163_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dm163_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm163_scan_ctrl_if.sv
// Bundle of the pixel-grid read port, the DM163 serial link and the
// column drive / status lines of the DM163 column scan controller.
interface dm163_scan_ctrl_if #(
    parameter int N_BITS = 192
);
    logic              enable;
    logic [N_BITS-1:0] col_bits;
    logic [2:0]        read_col_idx;
    logic              sda;
    logic              sck;
    logic              lat;
    logic [7:0]        col_sel;
    logic              busy;
    logic              frame_done;

    modport master (
        input  enable,
        input  col_bits,
        output read_col_idx,
        output sda,
        output sck,
        output lat,
        output col_sel,
        output busy,
        output frame_done
    );

    modport slave (
        output enable,
        output col_bits,
        input  read_col_idx,
        input  sda,
        input  sck,
        input  lat,
        input  col_sel,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/dm163_scan_ctrl.sv
// DM163 column scan controller: for each of 8 columns it captures the column
// data, shifts it MSB first into the DM163, latches it, then drives the
// column for a fixed dwell time while the rows stay blanked otherwise.
module dm163_scan_ctrl #(
    parameter int SCK_HALF = 2,
    parameter int DWELL    = 1000,
    parameter int N_BITS   = 192
) (
    input  logic               clk,
    input  logic               rst,
    dm163_scan_ctrl_if.master  bus
);

    localparam logic [15:0] SCK_LAST   = 16'(SCK_HALF - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [7:0]  BIT_LAST   = 8'(N_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    // One-hot column drive pattern for a column index.
    function automatic logic [7:0] col_onehot(input logic [2:0] col);
        col_onehot = 8'd1 << col;
    endfunction

    state_t              state_r, state_s;
    logic [2:0]          col_r, col_s;
    logic [7:0]          bit_cnt_r, bit_cnt_s;
    logic                half_r, half_s;      // 0: sck low half, 1: sck high half
    logic [15:0]         tmr_r, tmr_s;        // cycle timer within half-bit / latch / dwell
    logic [N_BITS-1:0]   shift_r, shift_s;

    logic                sda_r, sda_s;
    logic                sck_r, sck_s;
    logic                lat_r, lat_s;
    logic [7:0]          col_sel_r, col_sel_s;
    logic                busy_r, busy_s;
    logic                fd_r, fd_s;

    // Next-state, counter and output decode; outputs are derived from the
    // next state so the registered pins line up with the state they describe.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        bit_cnt_s = bit_cnt_r;
        half_s    = half_r;
        tmr_s     = tmr_r;
        shift_s   = shift_r;
        fd_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_s   = bus.col_bits;
                bit_cnt_s = 8'd0;
                half_s    = 1'b0;
                tmr_s     = 16'd0;
                state_s   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tmr_r == SCK_LAST) begin
                    tmr_s = 16'd0;
                    if (!half_r) begin
                        half_s = 1'b1;
                    end else begin
                        // Data advances only as sck falls, keeping sda stable while high.
                        half_s  = 1'b0;
                        shift_s = {shift_r[N_BITS-2:0], 1'b0};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_s = 8'd0;
                            state_s   = ST_LATCH;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 8'd1;
                        end
                    end
                end else begin
                    tmr_s = tmr_r + 16'd1;
                end
            end
            ST_LATCH: begin
                if (tmr_r == SCK_LAST) begin
                    tmr_s   = 16'd0;
                    state_s = ST_DISPLAY;
                end else begin
                    tmr_s = tmr_r + 16'd1;
                end
            end
            ST_DISPLAY: begin
                if (tmr_r == DWELL_LAST) begin
                    tmr_s = 16'd0;
                    col_s = col_r + 3'd1;
                    fd_s  = (col_r == 3'd7);
                    // Enable is only honoured here and in IDLE; a column never aborts.
                    if (bus.enable) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    tmr_s = tmr_r + 16'd1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                col_s     = 3'd0;
                bit_cnt_s = 8'd0;
                half_s    = 1'b0;
                tmr_s     = 16'd0;
                shift_s   = '0;
            end
        endcase

        sck_s     = (state_s == ST_SHIFT) && half_s;
        sda_s     = (state_s == ST_SHIFT) ? shift_s[N_BITS-1] : 1'b0;
        lat_s     = (state_s == ST_LATCH);
        col_sel_s = (state_s == ST_DISPLAY) ? col_onehot(col_s) : 8'h00;
        busy_s    = (state_s != ST_IDLE);
    end

    // State, counters, shift register and output pins, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            col_r     <= 3'd0;
            bit_cnt_r <= 8'd0;
            half_r    <= 1'b0;
            tmr_r     <= 16'd0;
            shift_r   <= '0;
            sda_r     <= 1'b0;
            sck_r     <= 1'b0;
            lat_r     <= 1'b0;
            col_sel_r <= 8'h00;
            busy_r    <= 1'b0;
            fd_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            col_r     <= col_s;
            bit_cnt_r <= bit_cnt_s;
            half_r    <= half_s;
            tmr_r     <= tmr_s;
            shift_r   <= shift_s;
            sda_r     <= sda_s;
            sck_r     <= sck_s;
            lat_r     <= lat_s;
            col_sel_r <= col_sel_s;
            busy_r    <= busy_s;
            fd_r      <= fd_s;
        end
    end

    assign bus.read_col_idx = col_r;
    assign bus.sda          = sda_r;
    assign bus.sck          = sck_r;
    assign bus.lat          = lat_r;
    assign bus.col_sel      = col_sel_r;
    assign bus.busy         = busy_r;
    assign bus.frame_done   = fd_r;

endmodule

// File: tb/tb_dm163_scan_ctrl.sv
// Bench for dm163_scan_ctrl: two instances (SCK_HALF=1 and SCK_HALF=3,
// DWELL=4) share stimulus and are compared every cycle against an
// offset-within-column reference model, plus directed waveform checks.
module tb_dm163_scan_ctrl;

    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [191:0] col_bits;

    always #5 clk = ~clk;

    dm163_scan_ctrl_if bus0 ();
    dm163_scan_ctrl_if bus1 ();

    assign bus0.enable   = enable;
    assign bus0.col_bits = col_bits;
    assign bus1.enable   = enable;
    assign bus1.col_bits = col_bits;

    dm163_scan_ctrl #(.SCK_HALF(1), .DWELL(DW), .N_BITS(192)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dm163_scan_ctrl #(.SCK_HALF(3), .DWELL(DW), .N_BITS(192)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int hs(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference model: whether a column is in progress, cycles since its LOAD,
    // the column number, the data captured at LOAD and the frame_done flag.
    bit           m_act [2];
    int           m_off [2];
    int           m_col [2];
    logic [191:0] m_dat [2];
    bit           m_fd  [2];

    function automatic logic [15:0] model_out(input int i);
        int         h;
        int         sh;
        int         s;
        logic       sda;
        logic       sck;
        logic       lat;
        logic [7:0] cs;
        h   = hs(i);
        sh  = 384 * h;
        sda = 1'b0;
        sck = 1'b0;
        lat = 1'b0;
        cs  = 8'h00;
        if (m_act[i] && m_off[i] >= 1 && m_off[i] <= sh) begin
            s   = m_off[i] - 1;
            sck = ((s % (2 * h)) >= h);
            sda = m_dat[i][191 - s / (2 * h)];
        end else if (m_act[i] && m_off[i] > sh && m_off[i] <= sh + h) begin
            lat = 1'b1;
        end else if (m_act[i] && m_off[i] > sh + h) begin
            cs = 8'd1 << m_col[i];
        end
        return {3'(m_col[i]), sda, sck, lat, cs, m_act[i], m_fd[i]};
    endfunction

    task automatic model_step(input int i);
        int period;
        period = 1 + 385 * hs(i) + DW;
        if (rst) begin
            m_act[i] = 1'b0;
            m_off[i] = 0;
            m_col[i] = 0;
            m_fd[i]  = 1'b0;
        end else begin
            m_fd[i] = 1'b0;
            if (!m_act[i]) begin
                if (enable) begin
                    m_act[i] = 1'b1;
                    m_off[i] = 0;
                end
            end else if (m_off[i] == 0) begin
                m_dat[i] = col_bits;
                m_off[i] = 1;
            end else if (m_off[i] == period - 1) begin
                m_fd[i]  = (m_col[i] == 7);
                m_col[i] = (m_col[i] + 1) % 8;
                if (enable) m_off[i] = 0;
                else        m_act[i] = 1'b0;
            end else begin
                m_off[i] = m_off[i] + 1;
            end
        end
    endtask

    // Directed first-column / first-frame measurements.
    bit           mon_on = 1'b0;
    bit           started [2];
    bit           done    [2];
    int           load_c  [2];
    int           rises   [2];
    int           latc    [2];
    int           selc    [2];
    int           per     [2];
    int           fd_c    [2];
    int           wrap_ix [2];
    int           sda_bad [2];
    logic         p_sck   [2];
    logic         p_sda   [2];
    logic [191:0] vec     [2];
    logic [7:0]   csq [$];

    task automatic monitor(input int i, input logic [15:0] o);
        logic [2:0] idx;
        idx = o[15:13];
        if (mon_on) begin
            if (!started[i] && o[1]) begin
                started[i] = 1'b1;
                load_c[i]  = cyc;
            end
            if (started[i] && !done[i]) begin
                if (idx != 3'd0) begin
                    done[i] = 1'b1;
                    per[i]  = cyc - load_c[i];
                end else begin
                    if (o[11] && !p_sck[i]) begin
                        rises[i]++;
                        vec[i] = {vec[i][190:0], o[12]};
                    end
                    if (o[11] && p_sck[i] && (o[12] != p_sda[i])) sda_bad[i]++;
                    if (o[10]) latc[i]++;
                    if (o[9:2] == 8'h01) selc[i]++;
                end
            end
            if (started[i] && o[0] && fd_c[i] < 0) begin
                fd_c[i]    = cyc - load_c[i];
                wrap_ix[i] = int'(idx);
            end
            if (i == 0 && o[9:2] != 8'h00 && (csq.size() == 0 || csq[$] != o[9:2])) csq.push_back(o[9:2]);
        end
        p_sck[i] = o[11];
        p_sda[i] = o[12];
    endtask

    task automatic tick();
        logic [15:0] o0;
        logic [15:0] o1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
        o0 = {bus0.read_col_idx, bus0.sda, bus0.sck, bus0.lat, bus0.col_sel, bus0.busy, bus0.frame_done};
        o1 = {bus1.read_col_idx, bus1.sda, bus1.sck, bus1.lat, bus1.col_sel, bus1.busy, bus1.frame_done};
        check_eq("dut0_pins", o0, model_out(0));
        check_eq("dut1_pins", o1, model_out(1));
        monitor(0, o0);
        monitor(1, o1);
    endtask

    function automatic logic [191:0] rnd192();
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r = {r[159:0], 32'($urandom)};
        return r;
    endfunction

    logic [191:0] pat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_off[i] = 0; m_col[i] = 0; m_fd[i] = 1'b0; m_dat[i] = '0;
            started[i] = 1'b0; done[i] = 1'b0; load_c[i] = 0; rises[i] = 0; latc[i] = 0;
            selc[i] = 0; per[i] = -1; fd_c[i] = -1; wrap_ix[i] = -1; sda_bad[i] = 0;
            p_sck[i] = 1'b0; p_sda[i] = 1'b0; vec[i] = '0;
        end
        pat      = {1'b1, 190'd0, 1'b1};
        rst      = 1'b1;
        enable   = 1'b0;
        col_bits = '0;
        mon_on   = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // Single column and full frame with fixed data, enable held high.
        rst      = 1'b0;
        enable   = 1'b1;
        col_bits = pat;
        for (int k = 0; k < 3200; k++) tick();
        mon_on = 1'b0;

        check_eq("d0_sck_rises", rises[0], 192);
        check_eq("d0_sda_seq", vec[0], pat);
        check_eq("d0_lat_cycles", latc[0], 1);
        check_eq("d0_colsel01_cycles", selc[0], DW);
        check_eq("d0_col_period", per[0], 390);
        check_eq("d0_frame_done_at", fd_c[0], 3120);
        check_eq("d0_idx_wrap", wrap_ix[0], 0);
        check_eq("d0_sda_stable_hi", sda_bad[0], 0);
        check_eq("d0_colsel_steps", csq.size() >= 8, 1);
        for (int k = 0; k < 8 && k < csq.size(); k++) check_eq("d0_colsel_step", csq[k], 8'd1 << k);
        check_eq("d1_sck_rises", rises[1], 192);
        check_eq("d1_sda_seq", vec[1], pat);
        check_eq("d1_lat_cycles", latc[1], 3);
        check_eq("d1_col_period", per[1], 1 + 1152 + 3 + DW);
        check_eq("d1_sda_stable_hi", sda_bad[1], 0);

        // Enable drop mid-SHIFT of column 2, with col_bits changing every cycle.
        for (int k = 0; k < 2000; k++) begin
            if (bus0.read_col_idx == 3'd2) break;
            col_bits = rnd192();
            tick();
        end
        for (int k = 0; k < 50; k++) begin
            col_bits = rnd192();
            tick();
        end
        enable = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (!bus0.busy && !bus1.busy) break;
            col_bits = rnd192();
            tick();
        end
        check_eq("d0_idle_after_drop", bus0.busy, 1'b0);
        check_eq("d0_idx_after_drop", bus0.read_col_idx, 3'd3);
        for (int k = 0; k < 5; k++) tick();
        enable = 1'b1;
        tick();
        check_eq("d0_resume_busy_idx", {bus0.busy, bus0.read_col_idx}, 4'b1011);
        for (int k = 0; k < 600; k++) begin
            if (bus0.col_sel != 8'h00) break;
            col_bits = rnd192();
            tick();
        end
        check_eq("d0_resume_col3", bus0.col_sel, 8'h08);

        // Reset during DISPLAY of column 5.
        for (int k = 0; k < 3000; k++) begin
            if (bus0.col_sel == 8'h20) break;
            col_bits = rnd192();
            tick();
        end
        check_eq("d0_reached_col5", bus0.col_sel, 8'h20);
        rst = 1'b1;
        tick();
        check_eq("d0_rst_outputs",
                 {bus0.read_col_idx, bus0.sda, bus0.sck, bus0.lat, bus0.col_sel, bus0.busy, bus0.frame_done}, 16'h0000);
        rst = 1'b0;
        tick();
        check_eq("d0_restart", {bus0.busy, bus0.read_col_idx}, 4'b1000);
        for (int k = 0; k < 600; k++) begin
            if (bus0.col_sel != 8'h00) break;
            tick();
        end
        check_eq("d0_restart_col0", bus0.col_sel, 8'h01);

        // Random enable/reset/data traffic against the model.
        for (int k = 0; k < 15000; k++) begin
            col_bits = rnd192();
            if ($urandom_range(299, 0) == 0) enable = ~enable;
            rst = ($urandom_range(2999, 0) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
